// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared constants and types for the data-memory arbiter.
//   DMEM_BASE_DEFAULT : byte address that maps to dmem word 0
//   TYPE_*            : dmem access size codes (passed through unchanged)
//   arb_state_e       : arbiter FSM encoding (previous-cycle owner)
package dmem_arbiter_pkg;

    localparam logic [31:0] DMEM_BASE_DEFAULT = 32'h1001_0000;

    localparam logic [1:0] TYPE_WORD = 2'd0;
    localparam logic [1:0] TYPE_HALF = 2'd1;
    localparam logic [1:0] TYPE_BYTE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PIPE = 2'd1,
        S_AUX  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmem_addr_xlate.sv
// dmem_addr_xlate: combinational byte-address to dmem word-index translation.
// Ports:
//   in_addr   : byte address
//   out_index : (in_addr - BASE) >> 2, 32-bit wrapping subtraction
//   out_oob   : address below BASE or index beyond the last dmem word
module dmem_addr_xlate
    import dmem_arbiter_pkg::*;
#(
    parameter logic [31:0] BASE  = DMEM_BASE_DEFAULT,
    parameter int unsigned WORDS = 1024
) (
    input  logic [31:0] in_addr,
    output logic [31:0] out_index,
    output logic        out_oob
);

    logic [31:0] offset;

    assign offset    = in_addr - BASE;
    assign out_index = {2'b00, offset[31:2]};
    assign out_oob   = (in_addr < BASE) || (out_index >= WORDS);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the pipeline MEM stage (P) and an
// auxiliary master (A). P has fixed priority; A is forced through after
// AUX_MAX_WAIT consecutive denials, stalling P for that one cycle.
// Optional build macro: DMEM_ARB_RANGE_CHECK_EN (blocks out-of-range accesses and
// adds out_range_err).
// Ports:
//   in_clk, in_rst          : clock, synchronous active-high reset
//   in_p_*                  : pipeline request (req/wena/type/addr/wdata)
//   out_p_stall/out_p_rdata : pipeline hold, same-cycle load data
//   in_a_*                  : aux request, held until granted
//   out_a_gnt               : aux access performed this cycle
//   out_a_rdata/out_a_rvalid: registered aux load data, one-cycle valid pulse
//   out_dmem_*/in_dmem_rdata: dmem interface (word index address)
//   out_range_err           : (macro only) registered out-of-range pulse
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE    = DMEM_BASE_DEFAULT,
    parameter int unsigned DMEM_WORDS   = 1024,
    parameter int unsigned AUX_MAX_WAIT = 4
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_p_req,
    input  logic        in_p_wena,
    input  logic [1:0]  in_p_type,
    input  logic [31:0] in_p_addr,
    input  logic [31:0] in_p_wdata,
    output logic        out_p_stall,
    output logic [31:0] out_p_rdata,
    input  logic        in_a_req,
    input  logic        in_a_wena,
    input  logic [1:0]  in_a_type,
    input  logic [31:0] in_a_addr,
    input  logic [31:0] in_a_wdata,
    output logic        out_a_gnt,
    output logic [31:0] out_a_rdata,
    output logic        out_a_rvalid,
    output logic        out_dmem_ena,
    output logic        out_dmem_wena,
    output logic [1:0]  out_dmem_type,
    output logic [31:0] out_dmem_addr,
    output logic [31:0] out_dmem_wdata,
    input  logic [31:0] in_dmem_rdata
`ifdef DMEM_ARB_RANGE_CHECK_EN
    ,
    output logic        out_range_err
`endif
);

    localparam logic [3:0] MAX_WAIT = 4'(AUX_MAX_WAIT);

    arb_state_e  state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic        p_gnt, a_gnt, any_gnt;
    logic [31:0] sel_addr, xlate_index;
    logic        xlate_oob, blocked;
    logic [31:0] a_rdata_q;
    logic        a_rvalid_q;

    // Arbitration, wait counter and next owner.
    always_comb begin
        p_gnt   = 1'b0;
        a_gnt   = 1'b0;
        state_d = S_IDLE;
        wait_d  = wait_q;
        if (!in_rst) begin
            if (in_p_req && in_a_req) begin
                // Right after an A grant P always wins, so P never stalls twice in a row.
                if (state_q == S_AUX || wait_q < MAX_WAIT) begin
                    p_gnt = 1'b1;
                end else begin
                    a_gnt = 1'b1;
                end
            end else if (in_p_req) begin
                p_gnt = 1'b1;
            end else if (in_a_req) begin
                a_gnt = 1'b1;
            end
        end
        if (p_gnt) begin
            state_d = S_PIPE;
        end else if (a_gnt) begin
            state_d = S_AUX;
        end
        if (!in_a_req || a_gnt) begin
            wait_d = 4'd0;
        end else if (p_gnt && wait_q < MAX_WAIT) begin
            wait_d = wait_q + 4'd1;
        end
    end

    assign any_gnt  = p_gnt || a_gnt;
    assign sel_addr = a_gnt ? in_a_addr : in_p_addr;

    dmem_addr_xlate #(
        .BASE  (DMEM_BASE),
        .WORDS (DMEM_WORDS)
    ) u_xlate (
        .in_addr   (sel_addr),
        .out_index (xlate_index),
        .out_oob   (xlate_oob)
    );

`ifdef DMEM_ARB_RANGE_CHECK_EN
    logic range_err_q;

    assign blocked       = xlate_oob;
    assign out_range_err = range_err_q;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= any_gnt && xlate_oob;
        end
    end
`else
    logic unused_oob;

    assign blocked    = 1'b0;
    assign unused_oob = xlate_oob;
`endif

    // dmem drive: the granted port, with enable/write masked for blocked accesses.
    always_comb begin
        out_dmem_ena   = 1'b0;
        out_dmem_wena  = 1'b0;
        out_dmem_type  = 2'd0;
        out_dmem_addr  = 32'd0;
        out_dmem_wdata = 32'd0;
        if (any_gnt) begin
            out_dmem_ena   = !blocked;
            out_dmem_wena  = (a_gnt ? in_a_wena : in_p_wena) && !blocked;
            out_dmem_type  = a_gnt ? in_a_type : in_p_type;
            out_dmem_addr  = xlate_index;
            out_dmem_wdata = a_gnt ? in_a_wdata : in_p_wdata;
        end
    end

    assign out_p_stall  = in_p_req && !p_gnt && !in_rst;
    assign out_p_rdata  = (p_gnt && !blocked) ? in_dmem_rdata : 32'd0;
    assign out_a_gnt    = a_gnt;
    assign out_a_rdata  = a_rdata_q;
    assign out_a_rvalid = a_rvalid_q;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q    <= S_IDLE;
            wait_q     <= 4'd0;
            a_rdata_q  <= 32'd0;
            a_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            a_rvalid_q <= a_gnt && !in_a_wena;
            if (a_gnt && !in_a_wena) begin
                a_rdata_q <= blocked ? 32'd0 : in_dmem_rdata;
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory between two requesters: the pipeline MEM stage (port P) and an auxiliary master such as a program loader or debug port (port A).
- Translates byte addresses to dmem word indices.
- Grants one access per cycle, with fixed priority to P and a starvation bound for A.
- Stalls the pipeline whenever A owns the memory.
- Sits between the MEM stage and the dmem instance.

Parameters:
- DMEM_BASE, 32'h10010000, byte address that maps to dmem word 0.
- DMEM_WORDS, 1024, dmem depth in words; sets the valid index range.
- AUX_MAX_WAIT, 4, consecutive cycles A may be denied before it is forced through; range 1..15.

Ports:
- in_clk  input  1  clock; all state updates on the rising edge.
- in_rst  input  1  reset, synchronous, active-high.
- in_p_req  input  1  pipeline memory access valid this cycle.
- in_p_wena  input  1  1 = store, 0 = load.
- in_p_type  input  2  access size code, passed unchanged to dmem.
- in_p_addr  input  32  byte address (ALU result).
- in_p_wdata  input  32  store data (rt value).
- out_p_stall  output  1  P request not served this cycle; pipeline must hold MEM and earlier stages.
- out_p_rdata  output  32  load data, combinational, valid the same cycle as the P grant.
- in_a_req  input  1  aux access valid; held until granted.
- in_a_wena  input  1  aux store/load select.
- in_a_type  input  2  aux access size code.
- in_a_addr  input  32  aux byte address.
- in_a_wdata  input  32  aux store data.
- out_a_gnt  output  1  aux access performed this cycle.
- out_a_rdata  output  32  registered aux load data.
- out_a_rvalid  output  1  out_a_rdata valid; one-cycle pulse.
- out_dmem_ena  output  1  dmem enable.
- out_dmem_wena  output  1  dmem write enable.
- out_dmem_type  output  2  dmem access type.
- out_dmem_addr  output  32  word index = (byte_addr - DMEM_BASE) >> 2.
- out_dmem_wdata  output  32  dmem write data.
- in_dmem_rdata  input  32  dmem read data; combinational from address.

Behaviour:
- Reset:
  - FSM enters S_IDLE; wait counter = 0.
  - out_a_rdata = 0; out_a_rvalid = 0.
  - All dmem controls are 0 while in_rst is high.
  - out_p_stall = 0; out_a_gnt = 0.
- FSM states record the previous-cycle owner: S_IDLE, S_PIPE, S_AUX.
  - Next state = owner of the current cycle, or S_IDLE when no access is granted.
- Arbitration (combinational in the current cycle):
  - P only: grant P.
  - A only: grant A.
  - Both requesting and wait_cnt < AUX_MAX_WAIT: grant P; wait_cnt += 1.
  - Both requesting and wait_cnt == AUX_MAX_WAIT: grant A; out_p_stall = 1.
- wait_cnt rules:
  - Clears on any A grant, and whenever in_a_req = 0.
  - Saturates at AUX_MAX_WAIT.
- Two consecutive A grants are forbidden while P is requesting. A cycle in S_AUX with in_p_req = 1 always grants P. This bounds P stall to one cycle per forced A access.
- Granted port drives the out_dmem_* signals:
  - out_dmem_ena = 1.
  - Address is translated as above with 32-bit wrapping subtraction.
  - When no grant: out_dmem_ena = 0, out_dmem_wena = 0, addr/wdata = 0.
- Read data:
  - out_p_rdata = in_dmem_rdata when P is granted, else 0.
  - A load: out_a_rdata is registered on the grant edge; out_a_rvalid is high the following cycle only.
  - A store: out_a_rvalid stays 0.
- Stores commit in dmem on the grant edge. No write buffering; latency is 0 for P and 1 for A read data.
- Reset asserted mid-access: the current access is dropped. No dmem write occurs in any cycle with in_rst = 1.

Optional Feature:
- Macro: DMEM_ARB_RANGE_CHECK_EN.
- When defined:
  - A granted access whose byte address is below DMEM_BASE, or whose word index is >= DMEM_WORDS, is blocked: out_dmem_ena = 0 and the write is suppressed.
  - The grant still completes (stall and arbitration are unchanged).
  - A loads return 0 with rvalid.
  - Extra output out_range_err (1 bit) is registered high for one cycle.
- When undefined: no check, the raw index is passed through, and out_range_err is absent.

Decomposition:
- Shared package holds:
  - DMEM_BASE default constant.
  - Access type codes (word/half/byte).
  - FSM state encoding (S_IDLE = 2'd0, S_PIPE = 2'd1, S_AUX = 2'd2).
- One natural sub-module, dmem_addr_xlate: combinational byte-to-word index translation plus range flag. It is reused by any future dmem master.

Test Plan:
- Reset: in_rst = 1 with both requests asserted -> out_dmem_ena = 0, out_a_rvalid = 0, out_p_stall = 0; after release the FSM is in S_IDLE.
- P only: P store addr 32'h10010008, data 32'hDEADBEEF -> out_dmem_addr = 2, out_dmem_wena = 1, out_p_stall = 0; a following P load at the same address returns 32'hDEADBEEF the same cycle.
- A only: A load addr 32'h10010008 -> out_a_gnt = 1; next cycle out_a_rvalid = 1 and out_a_rdata = 32'hDEADBEEF.
- Contention (AUX_MAX_WAIT = 4), both requesting continuously:
  - P is granted 4 cycles, then A is granted with out_p_stall = 1 for exactly one cycle, then P resumes.
  - The pattern repeats every 5 cycles.
- Reset mid-access: A store granted in the same cycle in_rst rises -> memory word is unchanged, and out_a_rvalid stays 0.
- Range (macro defined): A store to 32'h1000FFFC -> out_dmem_ena = 0, out_range_err pulses, and dmem contents are unchanged.
